// File: rtl/lgdst_spi3w_bridge.sv
// lgdst_spi3w_bridge: bridges the MCU 4-wire SPI port onto a shared 3-wire
// SPI bus (single bidirectional SDIO) serving NCH devices. Everything runs
// in the clk domain. The MCU pins are oversampled, forwarded with equal
// latency, and a small FSM tracks the command phase so it knows when to turn
// SDIO around for reads. The FSM also reports frame status and counts clean
// frames.
module lgdst_spi3w_bridge #(
  parameter int   NCH        = 2,
  parameter int   CMD_BITS   = 16,
  parameter int   RW_BIT_IDX = 0,
  parameter logic RD_LEVEL   = 1'b1,
  parameter int   CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi0_clk,
  input  logic [NCH-1:0]   spi0_cs,
  input  logic             spi0_mosi,
  output logic             spi0_miso,
  output logic             ad_spi_sclk,
  output logic [NCH-1:0]   ad_spi_cs,
  output logic             ad_sdio_o,
  output logic             ad_sdio_oe,
  input  logic             ad_sdio_i,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic             last_rw,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BW = $clog2(CMD_BITS + 1);
  localparam logic [BW-1:0] CMD_LAST = BW'(CMD_BITS);
  localparam logic [BW-1:0] RW_POS   = BW'(RW_BIT_IDX);

  typedef enum logic [2:0] {HOLD, IDLE, CMD, WR, RD} state_t;

  state_t state, state_next;

  logic           clk_m, s_clk, s_clk_d;
  logic [NCH-1:0] cs_m, s_cs;
  logic           mosi_m, s_mosi;

  logic [NCH-1:0] sel_mask;
  logic [BW-1:0]  bit_cnt;
  logic           rw;

  logic           rise, fall;
  logic [NCH-1:0] cs_low;
  logic           any_low, multi_low, sel_high, other_low;

  logic [NCH-1:0] cs_next;
  logic           oe_next, busy_next, done_next, err_next;
  logic           start, count_bit, cap_rw;

  // Two-flop synchronisers for the asynchronous MCU pins; left unreset so a
  // reset pulse never fakes a chip-select edge on the MCU side.
  always_ff @(posedge clk) begin
    clk_m   <= spi0_clk;
    s_clk   <= clk_m;
    s_clk_d <= s_clk;
    cs_m    <= spi0_cs;
    s_cs    <= cs_m;
    mosi_m  <= spi0_mosi;
    s_mosi  <= mosi_m;
  end

  assign rise      = s_clk & ~s_clk_d;
  assign fall      = ~s_clk & s_clk_d;
  assign cs_low    = ~s_cs;
  assign any_low   = |cs_low;
  assign multi_low = |(cs_low & (cs_low - NCH'(1)));
  assign sel_high  = |(s_cs & sel_mask);
  assign other_low = |(cs_low & ~sel_mask);

  // The read path back to the MCU is combinational; only the select is registered.
  assign spi0_miso = (state == RD) ? ad_sdio_i : 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= HOLD;
    else       state <= state_next;
  end

  // Next-state logic: a second chip select beats frame end, which beats bit events.
  always_comb begin
    state_next = state;
    case (state)
      HOLD: if (&s_cs) state_next = IDLE;
      IDLE: begin
        if (multi_low)    state_next = HOLD;
        else if (any_low) state_next = CMD;
      end
      CMD, WR, RD: begin
        if (other_low)     state_next = HOLD;
        else if (sel_high) state_next = IDLE;
        else if (state == CMD && fall && bit_cnt == CMD_LAST)
          state_next = (rw == RD_LEVEL) ? RD : WR;
      end
      default: state_next = HOLD;
    endcase
  end

  // Output decode: next values of the registered outputs plus datapath strobes.
  always_comb begin
    cs_next   = '1;
    oe_next   = 1'b0;
    busy_next = 1'b0;
    done_next = 1'b0;
    err_next  = 1'b0;
    start     = 1'b0;
    count_bit = 1'b0;
    cap_rw    = 1'b0;
    case (state)
      IDLE: begin
        if (multi_low) begin
          err_next = 1'b1;
        end else if (any_low) begin
          start     = 1'b1;
          cs_next   = s_cs;
          oe_next   = 1'b1;
          busy_next = 1'b1;
        end
      end
      CMD, WR, RD: begin
        if (other_low) begin
          err_next = 1'b1;
        end else if (sel_high) begin
          if (state == CMD && bit_cnt < CMD_LAST) err_next  = 1'b1;
          else                                    done_next = 1'b1;
        end else begin
          cs_next   = s_cs | ~sel_mask;
          busy_next = 1'b1;
          oe_next   = (state_next != RD);
          if (state == CMD && rise) begin
            count_bit = (bit_cnt != CMD_LAST);
            cap_rw    = (bit_cnt == RW_POS);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, forwarding path and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      ad_spi_sclk <= 1'b0;
      ad_sdio_o   <= 1'b0;
      ad_spi_cs   <= '1;
      ad_sdio_oe  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      last_rw     <= 1'b0;
      frame_cnt   <= '0;
      bit_cnt     <= '0;
      sel_mask    <= '0;
      rw          <= 1'b0;
    end else begin
      ad_spi_sclk <= s_clk;
      ad_sdio_o   <= s_mosi;
      ad_spi_cs   <= cs_next;
      ad_sdio_oe  <= oe_next;
      busy        <= busy_next;
      frame_done  <= done_next;
      frame_err   <= err_next;
      if (start) begin
        sel_mask <= cs_low;
        bit_cnt  <= '0;
        rw       <= 1'b0;
      end
      if (count_bit) bit_cnt <= bit_cnt + BW'(1);
      if (cap_rw)    rw      <= s_mosi;
      if (done_next) begin
        last_rw   <= (rw == RD_LEVEL);
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lgdst_spi3w_bridge.sv
// Testbench for lgdst_spi3w_bridge: an MCU-side SPI master task, a 3-wire
// device model that answers reads with 0xA5, a table of frames with
// hand-computed results, and hand-written reset and counter-wrap sequences.
module tb_lgdst_spi3w_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi0_clk = 1'b0;
  logic [1:0] spi0_cs = 2'b11;
  logic       spi0_mosi = 1'b0;
  logic       spi0_miso;
  logic       ad_spi_sclk;
  logic [1:0] ad_spi_cs;
  logic       ad_sdio_o;
  logic       ad_sdio_oe;
  logic       ad_sdio_i = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic       last_rw;
  logic [3:0] frame_cnt;

  lgdst_spi3w_bridge #(
    .NCH(2), .CMD_BITS(16), .RW_BIT_IDX(0), .RD_LEVEL(1'b1), .CNT_W(4)
  ) u_dut (
    .clk(clk), .reset(reset), .spi0_clk(spi0_clk), .spi0_cs(spi0_cs),
    .spi0_mosi(spi0_mosi), .spi0_miso(spi0_miso), .ad_spi_sclk(ad_spi_sclk),
    .ad_spi_cs(ad_spi_cs), .ad_sdio_o(ad_sdio_o), .ad_sdio_oe(ad_sdio_oe),
    .ad_sdio_i(ad_sdio_i), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .last_rw(last_rw), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Monitor counters (cumulative; tests look at deltas).
  int cyc = 0, n_done = 0, n_err = 0, oe_mis = 0, lat_err = 0;
  int cs0_low = 0, cs1_low = 0, fall_cnt = 0;
  int fall16_cyc = -100, oe_fall_cyc = -200;
  logic prev_sclk = 1'b0, prev_oe = 1'b0;
  logic [2:0] h_mosi = 3'b000, h_sclk = 3'b000;
  logic [7:0] dev_byte = 8'hA5;

  // Reset-time snapshots taken by the SPI task.
  logic rst_oe, rst_busy;
  logic [1:0] rst_cs;
  logic [3:0] rst_cnt;
  int rst_cs0 = 0;

  // Sampling monitor and 3-wire device model, 1 time unit after each active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    h_mosi = {h_mosi[1:0], spi0_mosi};
    h_sclk = {h_sclk[1:0], spi0_clk};
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (!ad_spi_cs[0]) cs0_low++;
    if (!ad_spi_cs[1]) cs1_low++;
    if (ad_sdio_oe !== (ad_spi_cs != 2'b11)) oe_mis++;
    if (!reset && cyc > 4 && (ad_sdio_o !== h_mosi[2] || ad_spi_sclk !== h_sclk[2])) lat_err++;
    if (prev_oe && !ad_sdio_oe) oe_fall_cyc = cyc;
    if (ad_spi_cs == 2'b11) begin
      fall_cnt = 0;
      ad_sdio_i = 1'b0;
    end else if (prev_sclk && !ad_spi_sclk) begin
      fall_cnt++;
      if (fall_cnt == 16) fall16_cyc = cyc;
      if (fall_cnt >= 16 && fall_cnt < 24) ad_sdio_i = dev_byte[23 - fall_cnt];
      else ad_sdio_i = 1'b0;
    end
    prev_sclk = ad_spi_sclk;
    prev_oe = ad_sdio_oe;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // MCU SPI master, mode 0, spi0_clk = clk/10. Optionally pulses reset at a given bit.
  task automatic apply_stimulus(input logic [1:0] cs, input logic [31:0] data, input int nbits,
                                input int reset_at, output logic [31:0] rx, output logic mid_busy);
    rx = 32'h0;
    mid_busy = 1'b0;
    spi0_cs = cs;
    spi0_mosi = data[nbits-1];
    wait_clk(5);
    for (int i = 0; i < nbits; i++) begin
      spi0_mosi = data[nbits-1-i];
      wait_clk(5);
      spi0_clk = 1'b1;
      rx = {rx[30:0], spi0_miso};
      if (i == nbits / 2) mid_busy = busy;
      if (i == reset_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        rst_oe = ad_sdio_oe;
        rst_cs = ad_spi_cs;
        rst_busy = busy;
        rst_cnt = frame_cnt;
        rst_cs0 = cs0_low;
        @(negedge clk);
        reset = 1'b0;
        wait_clk(4);
      end else begin
        wait_clk(5);
      end
      spi0_clk = 1'b0;
    end
    wait_clk(5);
    spi0_cs = 2'b11;
    spi0_mosi = 1'b0;
    wait_clk(10);
  endtask

  typedef struct {
    logic [1:0]  cs;
    logic [31:0] data;
    int          nbits;
    int          exp_done;
    int          exp_err;
    logic [3:0]  exp_cnt;
    logic        exp_rw;
    logic        exp_busy;
    logic        exp_cs0;
    logic        exp_cs1;
    logic [31:0] exp_rx;
    logic        is_read;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] rx;
    logic mid_busy;
    int d_done, d_err, d_oe, d_lat, d_c0, d_c1;

    //            cs     data          n   done err cnt  rw    busy  cs0   cs1   rx           read
    vecs[0] = '{2'b10, 32'h00123456, 24, 1, 0, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0};
    vecs[1] = '{2'b01, 32'h00800500, 24, 1, 0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h000000A5, 1'b1};
    vecs[2] = '{2'b10, 32'h00000012,  7, 0, 1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0};
    vecs[3] = '{2'b00, 32'h00123456, 24, 0, 1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      1'b0};
    vecs[4] = '{2'b10, 32'h00123456, 24, 1, 0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0};
    vecs[5] = '{2'b10, 32'h0000C000, 16, 1, 0, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,      1'b1};
    vecs[6] = '{2'b01, 32'h000001FF, 24, 1, 0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,      1'b0};
    vecs[7] = '{2'b01, 32'h00001234, 15, 0, 1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,      1'b0};

    // Reset values while reset is held.
    wait_clk(6);
    @(posedge clk);
    #1;
    check_output("rst_cs", 32'(ad_spi_cs), 32'h3);
    check_output("rst_sclk", 32'(ad_spi_sclk), 32'h0);
    check_output("rst_oe", 32'(ad_sdio_oe), 32'h0);
    check_output("rst_sdio_o", 32'(ad_sdio_o), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_done", 32'(frame_done), 32'h0);
    check_output("rst_err", 32'(frame_err), 32'h0);
    check_output("rst_last_rw", 32'(last_rw), 32'h0);
    check_output("rst_cnt", 32'(frame_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_clk(5);
    check_output("idle_miso", 32'(spi0_miso), 32'h0);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      d_done = n_done; d_err = n_err; d_oe = oe_mis; d_lat = lat_err;
      d_c0 = cs0_low; d_c1 = cs1_low;
      apply_stimulus(vecs[i].cs, vecs[i].data, vecs[i].nbits, -1, rx, mid_busy);
      check_output($sformatf("v%0d_done", i), 32'(n_done - d_done), 32'(vecs[i].exp_done));
      check_output($sformatf("v%0d_err", i), 32'(n_err - d_err), 32'(vecs[i].exp_err));
      check_output($sformatf("v%0d_cnt", i), 32'(frame_cnt), 32'(vecs[i].exp_cnt));
      check_output($sformatf("v%0d_last_rw", i), 32'(last_rw), 32'(vecs[i].exp_rw));
      check_output($sformatf("v%0d_mid_busy", i), 32'(mid_busy), 32'(vecs[i].exp_busy));
      check_output($sformatf("v%0d_end_busy", i), 32'(busy), 32'h0);
      check_output($sformatf("v%0d_end_oe", i), 32'(ad_sdio_oe), 32'h0);
      check_output($sformatf("v%0d_end_cs", i), 32'(ad_spi_cs), 32'h3);
      check_output($sformatf("v%0d_cs0_used", i), 32'((cs0_low - d_c0) > 0), 32'(vecs[i].exp_cs0));
      check_output($sformatf("v%0d_cs1_used", i), 32'((cs1_low - d_c1) > 0), 32'(vecs[i].exp_cs1));
      check_output($sformatf("v%0d_miso", i), rx, vecs[i].exp_rx);
      check_output($sformatf("v%0d_latency", i), 32'(lat_err - d_lat), 32'h0);
      if (vecs[i].is_read)
        check_output($sformatf("v%0d_turnaround", i),
                     32'((oe_fall_cyc - fall16_cyc) >= 0 && (oe_fall_cyc - fall16_cyc) <= 2), 32'h1);
      else
        check_output($sformatf("v%0d_oe_vs_cs", i), 32'(oe_mis - d_oe), 32'h0);
    end

    // Reset pulsed during bit 10 of a write frame on CS0.
    d_done = n_done; d_err = n_err;
    apply_stimulus(2'b10, 32'h00123456, 24, 10, rx, mid_busy);
    check_output("midrst_oe", 32'(rst_oe), 32'h0);
    check_output("midrst_cs", 32'(rst_cs), 32'h3);
    check_output("midrst_busy", 32'(rst_busy), 32'h0);
    check_output("midrst_cnt", 32'(rst_cnt), 32'h0);
    check_output("midrst_no_done", 32'(n_done - d_done), 32'h0);
    check_output("midrst_no_err", 32'(n_err - d_err), 32'h0);
    check_output("midrst_cs_ignored", 32'(cs0_low - rst_cs0), 32'h0);
    check_output("midrst_last_rw", 32'(last_rw), 32'h0);
    check_output("midrst_cnt_after", 32'(frame_cnt), 32'h0);

    // 17 clean writes on a 4-bit counter: 15 -> 0 -> 1.
    d_done = n_done; d_err = n_err;
    for (int f = 1; f <= 17; f++) begin
      apply_stimulus(2'b10, 32'h00000000, 16, -1, rx, mid_busy);
      if (f == 15) check_output("wrap_15", 32'(frame_cnt), 32'd15);
      if (f == 16) check_output("wrap_0", 32'(frame_cnt), 32'd0);
      if (f == 17) check_output("wrap_1", 32'(frame_cnt), 32'd1);
    end
    check_output("wrap_done", 32'(n_done - d_done), 32'd17);
    check_output("wrap_err", 32'(n_err - d_err), 32'd0);
    check_output("wrap_last_rw", 32'(last_rw), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lgdst_spi3w_bridge.md
Name: lgdst_spi3w_bridge

Overview:
Parametrised successor to the single-device 4-wire-to-3-wire SPI glue. Bridges the MCU 4-wire SPI port (spi0_*) onto a shared 3-wire SPI bus (single bidirectional SDIO) serving NCH RF devices, each with its own chip select. Fully synchronous: MCU SPI signals are oversampled in the clk domain, and the SDIO direction is derived from a configurable R/W bit position and command length. Adds frame status, error detection and a frame counter, which the earlier glue lacks.

Parameters:
NCH, 2, number of 3-wire devices / chip selects (1..8)
CMD_BITS, 16, SPI clocks in the command phase before SDIO turnaround (2..32)
RW_BIT_IDX, 0, 0-based index (MSB-first order) of the R/W bit within the frame; must be < CMD_BITS
RD_LEVEL, 1, value of the R/W bit that denotes a read
CNT_W, 16, width of frame_cnt

Ports:
clk  in  1  system clock; must be at least 8x spi0_clk
reset  in  1  synchronous, active-high
spi0_clk  in  1  MCU SPI clock, mode 0, async to clk
spi0_cs  in  NCH  MCU chip selects, active low, async
spi0_mosi  in  1  MCU data out
spi0_miso  out  1  MCU data in
ad_spi_sclk  out  1  3-wire bus clock
ad_spi_cs  out  NCH  3-wire chip selects, active low
ad_sdio_o  out  1  SDIO drive value
ad_sdio_oe  out  1  SDIO drive enable; top level builds the tristate
ad_sdio_i  in  1  SDIO pad input
busy  out  1  frame in progress
frame_done  out  1  1-cycle pulse on a clean frame end
frame_err  out  1  1-cycle pulse on an aborted or illegal frame
last_rw  out  1  R/W bit of the last completed frame (1 = read)
frame_cnt  out  CNT_W  count of clean frames; wraps

Behaviour:
- Synchronisation: spi0_clk, spi0_cs and spi0_mosi each pass through 2 flops to give s_clk, s_cs and s_mosi. rise = s_clk & ~s_clk_d; fall is the inverse.
- Forwarding: ad_spi_sclk = s_clk registered once. ad_sdio_o = s_mosi registered once. ad_spi_cs = s_cs registered once, but only for the selected channel; all other bits are forced high. Total latency from pin to output is 3 clk, identical for all three signals, so relative timing is preserved.
- spi0_miso = ad_sdio_i when in state RD, otherwise 0. The path is combinational; only the select is registered.
- Reset values: state=HOLD, ad_spi_cs all 1, ad_spi_sclk 0, ad_sdio_oe 0, ad_sdio_o 0, busy 0, frame_done 0, frame_err 0, last_rw 0, frame_cnt 0, bit_cnt 0.
- FSM states:
  - HOLD: oe=0. Go to IDLE once s_cs is all ones. Reset enters HOLD, so a frame already in progress when reset releases is ignored entirely.
  - IDLE: oe=0. If exactly one s_cs bit is low: latch sel, bit_cnt=0, busy=1, go to CMD. If more than one bit is low: pulse frame_err, go to HOLD.
  - CMD: oe=1.
    - On each rise: if bit_cnt==RW_BIT_IDX, rw<=s_mosi; then bit_cnt++.
    - On the first fall with bit_cnt==CMD_BITS: go to RD (oe=0 from the next cycle) if rw==RD_LEVEL, else go to WR.
  - WR: oe=1. Rises are ignored.
  - RD: oe=0. spi0_miso follows ad_sdio_i.
- Frame end: s_cs[sel] high in CMD, WR or RD.
  - If in CMD with bit_cnt<CMD_BITS: frame_err pulse.
  - Otherwise: frame_done pulse, last_rw<=(rw==RD_LEVEL), frame_cnt++ (wraps from all-ones to 0).
  - In both cases: busy=0, oe=0, next state IDLE.
- A second cs going low mid-frame in CMD, WR or RD: frame_err pulse, ad_spi_cs all high, go to HOLD. This check has priority over frame end in the same cycle.
- A rise and a cs deassert in the same cycle: the frame end wins and the bit is not counted.
- bit_cnt saturates at CMD_BITS. Width is clog2(CMD_BITS+1).
- Reset asserted in any state: all outputs return to their reset values on the next clk edge, with no frame_done or frame_err pulse.

Test Plan:
- NCH=2, CMD_BITS=16, RW_BIT_IDX=0, RD_LEVEL=1, CS0 low, 24-bit frame 0x12_34_56 (R/W=0), spi0_clk=clk/10 -> ad_spi_cs=2'b10; oe=1 for the whole frame; ad_sdio_o reproduces the bits 3 clk late; frame_done=1 once; last_rw=0; frame_cnt=1.
- CS1 low, frame 0x8005 followed by 8 read clocks while the device drives 0xA5 -> oe falls within 2 clk after the 16th falling edge; spi0_miso shifts out 0xA5; ad_spi_cs=2'b01; last_rw=1.
- CS0 deasserted after 7 clocks -> frame_err=1 once; frame_cnt unchanged; state IDLE; oe=0.
- spi0_cs=2'b00 at frame start -> frame_err pulse; ad_spi_cs stays 2'b11 for the whole frame; the next legal frame completes normally.
- reset pulsed for 1 cycle during bit 10 of a write -> oe=0 and ad_spi_cs=11 the next cycle; remaining clocks are ignored until cs goes high; no frame_done.
- CNT_W=4, 17 clean write frames -> frame_cnt goes 15 -> 0 -> 1.
